// File: rtl/sensor_fmt_pkg.sv
// rtl/sensor_fmt_pkg.sv - FSM states, ASCII constants and frame length for the sensor text formatter
// FMT_CHECKSUM_EN selects the 22-byte frame with the "*XY" checksum field.
package sensor_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND,
    ST_WAIT,
    ST_FIN,
    ST_ABORT
  } fmt_state_e;

  localparam logic [7:0] ASC_H    = 8'h48;
  localparam logic [7:0] ASC_T    = 8'h54;
  localparam logic [7:0] ASC_D    = 8'h44;
  localparam logic [7:0] ASC_EQ   = 8'h3D;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_STAR = 8'h2A;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_ZERO = 8'h30;

`ifdef FMT_CHECKSUM_EN
  localparam int FRAME_LEN = 22;
`else
  localparam int FRAME_LEN = 19;
`endif

  function automatic logic [7:0] dec_ascii(input logic [3:0] n);
    return ASC_ZERO + {4'h0, n};
  endfunction

  // Uppercase hex: 'A' is 8'h41 = 8'h37 + 10.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASC_ZERO + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_sensor_tx_fmt_if.sv
// rtl/uart_sensor_tx_fmt_if.sv - byte launch handshake between the formatter and the UART transmitter
interface uart_sensor_tx_fmt_if;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_tx_done;

  modport master (output o_tx_start, output o_tx_data, input i_tx_busy, input i_tx_done);
  modport slave  (input o_tx_start, input o_tx_data, output i_tx_busy, output i_tx_done);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble, 10-bit binary to 3 BCD digits, one shift per cycle
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [21:0] sr;
  logic [3:0]  cnt;
  logic        run;

  function automatic logic [21:0] dabble(input logic [21:0] s);
    logic [21:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[10 + 4*i +: 4] >= 4'd5) a[10 + 4*i +: 4] = a[10 + 4*i +: 4] + 4'd3;
    end
    return {a[20:0], 1'b0};
  endfunction

  // The load cycle also performs the first shift, so a result takes 10 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= dabble({12'h000, bin});
        cnt <= 4'd1;
        run <= 1'b1;
      end else if (run) begin
        sr  <= dabble(sr);
        cnt <= cnt + 4'd1;
        if (cnt == 4'd9) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr[21:10];
endmodule

// File: rtl/uart_sensor_tx_fmt.sv
// rtl/uart_sensor_tx_fmt.sv - snapshots sensors and streams "H=hhh T=ttt D=ddd\r\n" into the UART TX handshake
// FMT_CHECKSUM_EN inserts "*XY" (hex XOR of the text bytes) before CR LF.
module uart_sensor_tx_fmt
  import sensor_fmt_pkg::*;
#(
  parameter int DIST_W       = 9,
  parameter int DONE_TIMEOUT = 2_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_send,
  input  logic [7:0]        i_humi,
  input  logic [7:0]        i_temp,
  input  logic [DIST_W-1:0] i_dist,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err,
  uart_sensor_tx_fmt_if.master tx
);
  localparam int               TMO_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [4:0]       LAST_IDX = 5'(FRAME_LEN - 1);

  fmt_state_e       state;
  logic [9:0]       humi_q, temp_q, dist_q, conv_bin, dist_clamped;
  logic [31:0]      dist_ext;
  logic [11:0]      humi_bcd, temp_bcd, dist_bcd, conv_bcd;
  logic [1:0]       field;
  logic             conv_start, conv_done;
  logic [4:0]       idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       tx_byte;
`ifdef FMT_CHECKSUM_EN
  localparam logic [4:0] CSUM_END = 5'd17;
  logic [7:0] csum;
`endif

  assign dist_ext     = 32'(i_dist);
  assign dist_clamped = (dist_ext > 32'd999) ? 10'd999 : dist_ext[9:0];

  always_comb begin
    case (field)
      2'd0:    conv_bin = humi_q;
      2'd1:    conv_bin = temp_q;
      default: conv_bin = dist_q;
    endcase
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    tx_byte = ASC_LF;
    case (idx)
      5'd0:  tx_byte = ASC_H;
      5'd1:  tx_byte = ASC_EQ;
      5'd2:  tx_byte = dec_ascii(humi_bcd[11:8]);
      5'd3:  tx_byte = dec_ascii(humi_bcd[7:4]);
      5'd4:  tx_byte = dec_ascii(humi_bcd[3:0]);
      5'd5:  tx_byte = ASC_SP;
      5'd6:  tx_byte = ASC_T;
      5'd7:  tx_byte = ASC_EQ;
      5'd8:  tx_byte = dec_ascii(temp_bcd[11:8]);
      5'd9:  tx_byte = dec_ascii(temp_bcd[7:4]);
      5'd10: tx_byte = dec_ascii(temp_bcd[3:0]);
      5'd11: tx_byte = ASC_SP;
      5'd12: tx_byte = ASC_D;
      5'd13: tx_byte = ASC_EQ;
      5'd14: tx_byte = dec_ascii(dist_bcd[11:8]);
      5'd15: tx_byte = dec_ascii(dist_bcd[7:4]);
      5'd16: tx_byte = dec_ascii(dist_bcd[3:0]);
`ifdef FMT_CHECKSUM_EN
      5'd17: tx_byte = ASC_STAR;
      5'd18: tx_byte = hex_ascii(csum[7:4]);
      5'd19: tx_byte = hex_ascii(csum[3:0]);
      5'd20: tx_byte = ASC_CR;
`else
      5'd17: tx_byte = ASC_CR;
`endif
      default: tx_byte = ASC_LF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      humi_q        <= '0;
      temp_q        <= '0;
      dist_q        <= '0;
      humi_bcd      <= '0;
      temp_bcd      <= '0;
      dist_bcd      <= '0;
      field         <= '0;
      conv_start    <= 1'b0;
      idx           <= '0;
      tmo_cnt       <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
      tx.o_tx_start <= 1'b0;
      tx.o_tx_data  <= 8'h00;
`ifdef FMT_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      tx.o_tx_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
      conv_start    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_send) begin
            humi_q     <= {2'b00, i_humi};
            temp_q     <= {2'b00, i_temp};
            dist_q     <= dist_clamped;
            o_busy     <= 1'b1;
            idx        <= '0;
            field      <= '0;
            conv_start <= 1'b1;
            state      <= ST_CONV;
`ifdef FMT_CHECKSUM_EN
            csum       <= 8'h00;
`endif
          end
        end
        // One converter serves humi, temp, dist in turn; the next start overlaps the store.
        ST_CONV: begin
          if (conv_done) begin
            case (field)
              2'd0:    humi_bcd <= conv_bcd;
              2'd1:    temp_bcd <= conv_bcd;
              default: dist_bcd <= conv_bcd;
            endcase
            if (field == 2'd2) begin
              state <= ST_SEND;
            end else begin
              field      <= field + 2'd1;
              conv_start <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          tx.o_tx_data <= tx_byte;
          if (!tx.i_tx_busy) begin
            tx.o_tx_start <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ST_WAIT;
`ifdef FMT_CHECKSUM_EN
            if (idx < CSUM_END) csum <= csum ^ tx_byte;
`endif
          end
        end
        ST_WAIT: begin
          if (tx.i_tx_done) begin
            if (idx == LAST_IDX) begin
              o_frame_done <= 1'b1;
              o_busy       <= 1'b0;
              state        <= ST_FIN;
            end else begin
              idx   <= idx + 5'd1;
              state <= ST_SEND;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_ABORT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_FIN, ST_ABORT: state <= ST_IDLE;
        default:          state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sensor_tx_fmt.sv
// tb/tb_uart_sensor_tx_fmt.sv - randomized self-checking bench for uart_sensor_tx_fmt with a UART responder model
module tb_uart_sensor_tx_fmt;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_send;
  logic [7:0] i_humi, i_temp;
  logic [9:0] i_dist;
  logic       o_busy, o_frame_done, o_err;

  uart_sensor_tx_fmt_if tx ();

  logic       hold_busy, no_done, resp_busy, resp_done;
  int         clear_req, clear_seen, resp_cnt;
  logic [7:0] cap[$];
  time        start_t[$];
  int         n_frame_done, n_err, n_start_busy, n_unstable;
  int         n_checks, n_pass;

  always #5 clk = ~clk;

  assign tx.i_tx_busy = resp_busy | hold_busy;
  assign tx.i_tx_done = resp_done;

  uart_sensor_tx_fmt #(.DIST_W(10), .DONE_TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_send       (i_send),
    .i_humi       (i_humi),
    .i_temp       (i_temp),
    .i_dist       (i_dist),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err),
    .tx           (tx)
  );

  // UART responder: busy right after a start, done pulse 20 cycles later.
  initial begin
    resp_busy = 1'b0; resp_done = 1'b0; resp_cnt = 0; clear_seen = 0;
    n_frame_done = 0; n_err = 0; n_start_busy = 0; n_unstable = 0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (clear_req != clear_seen) begin
        clear_seen = clear_req; resp_busy = 1'b0; resp_cnt = 0;
      end
      if (o_frame_done === 1'b1) n_frame_done++;
      if (o_err === 1'b1) n_err++;
      if (tx.o_tx_start === 1'b1) begin
        if (tx.i_tx_busy !== 1'b0) n_start_busy++;
        cap.push_back(tx.o_tx_data);
        start_t.push_back($time);
        resp_busy = 1'b1;
        resp_cnt  = 20;
      end else if (resp_busy) begin
        if (tx.o_tx_data !== cap[$]) n_unstable++;
        if (!no_done) begin
          resp_cnt--;
          if (resp_cnt == 0) begin resp_done = 1'b1; resp_busy = 1'b0; end
        end
      end
    end
  end

  function automatic string model_frame(input int h, input int t, input int d);
    string s;
    logic [7:0] x;
    int dc;
    dc = (d > 999) ? 999 : d;
    s = $sformatf("H=%03d T=%03d D=%03d", h, t, dc);
`ifdef FMT_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < s.len(); i++) x = x ^ s[i];
    s = {s, $sformatf("*%02X", x)};
`else
    x = 8'h00;
`endif
    return {s, "\r\n", (x === 8'hxx) ? "?" : ""};
  endfunction

  function automatic string printable(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] < 8'h20) r = {r, "."};
      else r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  task automatic do_frame(input int h, input int t, input int d, input int hold, input bit noise,
                          output string got, output int lat, output int early, output bit busy_seen,
                          output int d_done, output int d_err);
    int  base, b_done, b_err;
    time t_send;
    bit  fin, noised;
    base = cap.size(); b_done = n_frame_done; b_err = n_err;
    hold_busy = (hold > 0);
    @(negedge clk);
    i_humi = 8'(h); i_temp = 8'(t); i_dist = 10'(d); i_send = 1'b1; t_send = $time;
    @(negedge clk);
    i_send = 1'b0;
    busy_seen = o_busy;
    early = 0;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      early = cap.size() - base;
      hold_busy = 1'b0;
    end
    fin = 1'b0; noised = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      if (noise && !noised && (cap.size() - base) >= 5) begin
        noised = 1'b1;
        for (int p = 0; p < 3; p++) begin
          i_humi = 8'($urandom); i_temp = 8'($urandom); i_dist = 10'($urandom);
          i_send = 1'b1;
          @(negedge clk);
          i_send = 1'b0;
          @(negedge clk);
        end
      end
      if (n_frame_done != b_done || n_err != b_err) fin = 1'b1;
    end
    @(negedge clk);
    got = "";
    for (int i = base; i < cap.size(); i++) got = {got, $sformatf("%c", cap[i])};
    lat = (cap.size() > base) ? int'((start_t[base] - t_send) / 10) : -1;
    d_done = n_frame_done - b_done;
    d_err  = n_err - b_err;
  endtask

  task automatic test_reset();
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (tx.o_tx_start !== 1'b0) $display("FAIL reset_start: got %b want 0", tx.o_tx_start); else n_pass++;
    n_checks++; if (tx.o_tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx.o_tx_data); else n_pass++;
    n_checks++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", o_frame_done); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_err); else n_pass++;
  endtask

  task automatic test_basic();
    string got, lit;
    int lat, early, dd, de;
    bit bs;
`ifdef FMT_CHECKSUM_EN
    lit = "H=045 T=023 D=123*55\r\n";
`else
    lit = "H=045 T=023 D=123\r\n";
`endif
    do_frame(45, 23, 123, 0, 1'b0, got, lat, early, bs, dd, de);
    n_checks++; if (got != lit) $display("FAIL basic_frame: got \"%s\" want \"%s\"", printable(got), printable(lit)); else n_pass++;
    n_checks++; if (got.len() != lit.len()) $display("FAIL basic_starts: got %0d want %0d", got.len(), lit.len()); else n_pass++;
    n_checks++; if (dd !== 1) $display("FAIL basic_frame_done: got %0d want 1", dd); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (bs !== 1'b1) $display("FAIL basic_busy_during: got %b want 1", bs); else n_pass++;
    n_checks++; if (lat < 0 || lat > 36) $display("FAIL basic_latency: got %0d want <=36", lat); else n_pass++;
  endtask

  task automatic test_random();
    string got, exp;
    int h, t, d, lat, early, dd, de;
    bit bs;
    for (int n = 0; n < 4; n++) begin
      h = int'($urandom_range(0, 255)); t = int'($urandom_range(0, 255)); d = int'($urandom_range(0, 1023));
      exp = model_frame(h, t, d);
      do_frame(h, t, d, 0, 1'b0, got, lat, early, bs, dd, de);
      n_checks++; if (got != exp || dd !== 1) $display("FAIL random_frame%0d: got \"%s\" done %0d want \"%s\" done 1", n, printable(got), dd, printable(exp)); else n_pass++;
      n_checks++; if (lat < 0 || lat > 36) $display("FAIL random_latency%0d: got %0d want <=36", n, lat); else n_pass++;
    end
  endtask

  task automatic test_clamp();
    string got, exp;
    int lat, early, dd, de;
    bit bs;
    int vals[3][3] = '{'{0, 255, 511}, '{7, 99, 1000}, '{100, 9, 1023}};
    for (int n = 0; n < 3; n++) begin
      exp = model_frame(vals[n][0], vals[n][1], vals[n][2]);
      do_frame(vals[n][0], vals[n][1], vals[n][2], 0, 1'b0, got, lat, early, bs, dd, de);
      n_checks++; if (got != exp) $display("FAIL clamp_frame%0d: got \"%s\" want \"%s\"", n, printable(got), printable(exp)); else n_pass++;
    end
  endtask

  task automatic test_ignored_send();
    string got, exp;
    int h, t, d, lat, early, dd, de;
    bit bs;
    h = int'($urandom_range(0, 255)); t = int'($urandom_range(0, 255)); d = int'($urandom_range(0, 1023));
    exp = model_frame(h, t, d);
    do_frame(h, t, d, 0, 1'b1, got, lat, early, bs, dd, de);
    repeat (60) @(negedge clk);
    n_checks++; if (got != exp) $display("FAIL ignored_send_frame: got \"%s\" want \"%s\"", printable(got), printable(exp)); else n_pass++;
    n_checks++; if (dd !== 1) $display("FAIL ignored_send_done: got %0d want 1", dd); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL ignored_send_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_busy_hold();
    string got, exp;
    int lat, early, dd, de;
    bit bs;
    exp = model_frame(12, 34, 56);
    do_frame(12, 34, 56, 100, 1'b0, got, lat, early, bs, dd, de);
    n_checks++; if (early !== 0) $display("FAIL busy_hold_early: got %0d starts want 0", early); else n_pass++;
    n_checks++; if (got != exp) $display("FAIL busy_hold_frame: got \"%s\" want \"%s\"", printable(got), printable(exp)); else n_pass++;
  endtask

  task automatic test_async_reset();
    string got, exp;
    int base, lat, early, dd, de, b_done;
    bit bs;
    base = cap.size(); b_done = n_frame_done;
    @(negedge clk);
    i_humi = 8'd77; i_temp = 8'd88; i_dist = 10'd321; i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    for (int k = 0; k < 2000 && (cap.size() - base) < 7; k++) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if ({tx.o_tx_start, tx.o_tx_data} !== 9'h000) $display("FAIL areset_tx: got start %b data %h want 0 00", tx.o_tx_start, tx.o_tx_data); else n_pass++;
    n_checks++; if ({o_frame_done, o_err} !== 2'b00) $display("FAIL areset_pulses: got %b want 00", {o_frame_done, o_err}); else n_pass++;
    clear_req++;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if ((cap.size() - base) !== 7 || n_frame_done !== b_done) $display("FAIL areset_no_more: got %0d bytes %0d done want 7 bytes 0 done", cap.size() - base, n_frame_done - b_done); else n_pass++;
    exp = model_frame(201, 5, 640);
    do_frame(201, 5, 640, 0, 1'b0, got, lat, early, bs, dd, de);
    n_checks++; if (got != exp) $display("FAIL areset_next_frame: got \"%s\" want \"%s\"", printable(got), printable(exp)); else n_pass++;
  endtask

  task automatic test_timeout();
    string got, exp;
    int lat, early, dd, de;
    bit bs;
    no_done = 1'b1;
    do_frame(45, 23, 123, 0, 1'b0, got, lat, early, bs, dd, de);
    n_checks++; if (de !== 1) $display("FAIL timeout_err: got %0d pulses want 1", de); else n_pass++;
    n_checks++; if (dd !== 0) $display("FAIL timeout_no_done: got %0d want 0", dd); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (got != "H") $display("FAIL timeout_bytes: got \"%s\" want \"H\"", printable(got)); else n_pass++;
    no_done = 1'b0;
    clear_req++;
    repeat (3) @(negedge clk);
    exp = model_frame(1, 2, 3);
    do_frame(1, 2, 3, 0, 1'b0, got, lat, early, bs, dd, de);
    n_checks++; if (got != exp || dd !== 1) $display("FAIL timeout_recover: got \"%s\" done %0d want \"%s\" done 1", printable(got), dd, printable(exp)); else n_pass++;
  endtask

  task automatic test_protocol();
    n_checks++; if (n_start_busy !== 0) $display("FAIL start_while_busy: got %0d want 0", n_start_busy); else n_pass++;
    n_checks++; if (n_unstable !== 0) $display("FAIL data_unstable: got %0d want 0", n_unstable); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; i_send = 1'b0; i_humi = 8'h00; i_temp = 8'h00; i_dist = 10'h000;
    hold_busy = 1'b0; no_done = 1'b0; clear_req = 0;
    n_checks = 0; n_pass = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_random();
    test_clamp();
    test_ignored_send();
    test_busy_hold();
    test_async_reset();
    test_timeout();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
